lector_7seg: RTL and testbench



---
 rtl/pkg_7seg.sv | 69 ++++++
 rtl/seg7_a_bcd.sv | 36 +++
 rtl/lector_7seg.sv | 188 ++++++++++++++++++
 tb/tb_lector_7seg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_7seg.sv
// Shared constants and types for the 7-segment bus reader.
// Cathode patterns are active-low {g,f,e,d,c,b,a}.
package pkg_7seg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_O   = 7'h23;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0] AN_PRIMER  = 4'b1110;
  localparam logic [3:0] AN_SEGUNDO = 4'b1101;
  localparam logic [3:0] AN_TERCER  = 4'b1011;
  localparam logic [3:0] AN_CUARTO  = 4'b0111;
  localparam logic [3:0] AN_BLANK   = 4'b1111;

  typedef enum logic [1:0] {
    S_WAIT,
    S_QUALIFY,
    S_LOCKED
  } state_t;

  typedef enum logic [1:0] {
    AN_OK,
    AN_OFF,
    AN_BAD
  } an_class_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

  localparam sample_t SAMPLE_IDLE = '{an: AN_BLANK, seg: SEG_OFF};

  function automatic an_class_t an_class(input logic [3:0] an);
    an_class_t c;
    unique case (an)
      AN_PRIMER, AN_SEGUNDO,
      AN_TERCER, AN_CUARTO: c = AN_OK;
      AN_BLANK:             c = AN_OFF;
      default:              c = AN_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] i;
    case (an)
      AN_SEGUNDO: i = 2'd1;
      AN_TERCER:  i = 2'd2;
      AN_CUARTO:  i = 2'd3;
      default:    i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/seg7_a_bcd.sv
// Inverse of the writer's BCD_to_7seg: cathode pattern to code.
// Unknown patterns decode to F and raise illegal_o.
module seg7_a_bcd
  import pkg_7seg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       illegal_o
);

  // Table lookup; anything off-table is blank plus a flag.
  always_comb begin
    code_o    = 4'hF;
    illegal_o = 1'b0;
    unique case (seg_i)
      SEG_0:   code_o = 4'h0;
      SEG_1:   code_o = 4'h1;
      SEG_2:   code_o = 4'h2;
      SEG_3:   code_o = 4'h3;
      SEG_4:   code_o = 4'h4;
      SEG_5:   code_o = 4'h5;
      SEG_6:   code_o = 4'h6;
      SEG_7:   code_o = 4'h7;
      SEG_8:   code_o = 4'h8;
      SEG_9:   code_o = 4'h9;
      SEG_A:   code_o = 4'hA;
      SEG_O:   code_o = 4'hB;
      SEG_C:   code_o = 4'hC;
      SEG_D:   code_o = 4'hD;
      SEG_E:   code_o = 4'hE;
      SEG_OFF: code_o = 4'hF;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lector_7seg.sv
// Multiplexed 7-segment bus reader: debounces each digit dwell
// and publishes all four codes together once per full scan.
module lector_7seg
  import pkg_7seg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] catodo_i,
  input  logic [3:0] anodo_i,
  input  logic       clr_err_i,
  output logic [3:0] primer_disp_o,
  output logic [3:0] segundo_disp_o,
  output logic [3:0] tercer_disp_o,
  output logic [3:0] cuarto_disp_o,
  output logic       frame_valid_o,
  output logic       err_o,
  output logic       stale_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYCLES - 1);

  sample_t       in_q;
  sample_t       prev_q;
  state_t        state;
  state_t        state_n;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] cnt_n;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    seen;
  logic [3:0]    seen_base;
  logic [3:0]    bit_sel;
  logic [3:0]    shadow [4];
  logic          frame_pend;
  logic          acc;
  logic          same;
  logic          tmo;
  logic          err_set;
  an_class_t     cls;
  logic [1:0]    idx;
  logic [3:0]    code;
  logic          illegal;
  logic          unused_dp;

  assign unused_dp = catodo_i[7];

  assign same    = (in_q == prev_q);
  assign cls     = an_class(in_q.an);
  assign idx     = an_index(in_q.an);
  assign bit_sel = 4'(1) << idx;

  seg7_a_bcd u_dec (
    .seg_i     (in_q.seg),
    .code_o    (code),
    .illegal_o (illegal)
  );

  // A completed frame empties the mask before this cycle's accept.
  assign seen_base = frame_pend ? 4'b0000 : seen;
  assign tmo       = !acc && (idle_cnt == T_PRE);
  assign err_set   = (cls == AN_BAD) || (acc && illegal);

  // Single registration of the bus, plus the previous sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q   <= SAMPLE_IDLE;
      prev_q <= SAMPLE_IDLE;
    end else begin
      in_q   <= {anodo_i, catodo_i[6:0]};
      prev_q <= in_q;
    end
  end

  // Qualification FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_WAIT;
      stab_cnt <= '0;
    end else begin
      state    <= state_n;
      stab_cnt <= cnt_n;
    end
  end

  // Next state: count identical samples, accept once per dwell.
  always_comb begin
    state_n = state;
    cnt_n   = stab_cnt;
    acc     = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (cls == AN_OK) begin
          cnt_n   = S_ONE;
          state_n = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (cls != AN_OK) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else if (same) begin
          cnt_n = stab_cnt + S_ONE;
        end else begin
          cnt_n = S_ONE;
        end
      end
      S_LOCKED: begin
        if (!same) begin
          if (cls == AN_OK) begin
            cnt_n   = S_ONE;
            state_n = S_QUALIFY;
          end else begin
            cnt_n   = '0;
            state_n = S_WAIT;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
    endcase
    if (state_n == S_QUALIFY && cnt_n == S_MAX) begin
      acc     = 1'b1;
      state_n = S_LOCKED;
    end
  end

  // Shadows, seen mask and atomic publish of the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) shadow[i] <= 4'hF;
      seen           <= 4'b0000;
      frame_pend     <= 1'b0;
      frame_valid_o  <= 1'b0;
      primer_disp_o  <= 4'hF;
      segundo_disp_o <= 4'hF;
      tercer_disp_o  <= 4'hF;
      cuarto_disp_o  <= 4'hF;
    end else begin
      frame_valid_o <= frame_pend;
      if (frame_pend) begin
        primer_disp_o  <= shadow[0];
        segundo_disp_o <= shadow[1];
        tercer_disp_o  <= shadow[2];
        cuarto_disp_o  <= shadow[3];
      end
      if (acc) begin
        shadow[idx] <= code;
        seen        <= seen_base | bit_sel;
      end else if (tmo) begin
        seen <= 4'b0000;
      end else begin
        seen <= seen_base;
      end
      frame_pend <= acc && ((seen_base | bit_sel) == 4'hF);
    end
  end

  // Idle timeout, stale flag and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
      stale_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (acc) begin
        idle_cnt <= '0;
      end else if (idle_cnt != T_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
      if (tmo) begin
        stale_o <= 1'b1;
      end else if (frame_pend) begin
        stale_o <= 1'b0;
      end
      err_o <= err_set || (err_o && !clr_err_i);
    end
  end

endmodule

// File: tb/tb_lector_7seg.sv
// Bench for lector_7seg: directed scans plus random dwells,
// compared every cycle against a sample-history model.
module tb_lector_7seg;

  localparam int S = 4;
  localparam int T = 16;

  localparam logic [6:0] PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h23, 7'h46, 7'h21, 7'h06, 7'h7F
  };

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] catodo_i;
  logic [3:0] anodo_i;
  logic       clr_err_i;
  logic [3:0] primer_disp_o;
  logic [3:0] segundo_disp_o;
  logic [3:0] tercer_disp_o;
  logic [3:0] cuarto_disp_o;
  logic       frame_valid_o;
  logic       err_o;
  logic       stale_o;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic stale_at_pulse = 1'b1;

  logic [3:0]  m_sh [4];
  logic [3:0]  m_out [4];
  bit          m_seen [4];
  bit          m_fv, m_err, m_stale;
  int          m_idle;
  int          m_run_len;
  logic [10:0] m_run_val;
  bit          m_pacc, m_pbad, m_pill_an, m_pframe;
  int          m_pidx;
  logic [3:0]  m_pcode;

  lector_7seg #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .catodo_i       (catodo_i),
    .anodo_i        (anodo_i),
    .clr_err_i      (clr_err_i),
    .primer_disp_o  (primer_disp_o),
    .segundo_disp_o (segundo_disp_o),
    .tercer_disp_o  (tercer_disp_o),
    .cuarto_disp_o  (cuarto_disp_o),
    .frame_valid_o  (frame_valid_o),
    .err_o          (err_o),
    .stale_o        (stale_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [6:0] p,
                                 output logic [3:0] c,
                                 output bit bad);
    c   = 4'hF;
    bad = 1'b1;
    for (int i = 0; i < 16; i++)
      if (PAT[i] == p) begin
        c   = 4'(i);
        bad = 1'b0;
      end
  endfunction

  // One clock edge of the reference behaviour, sample (an,sg) taken.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] sg,
                            input logic clr, input logic rs);
    bit all_seen;
    bit valid;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 4'hF; m_out[i] = 4'hF; m_seen[i] = 1'b0;
      end
      m_fv = 0; m_err = 0; m_stale = 0; m_idle = 0;
      m_run_len = 0; m_pacc = 0; m_pill_an = 0; m_pframe = 0;
    end else begin
      m_fv = m_pframe;
      if (m_pframe) begin
        for (int i = 0; i < 4; i++) begin
          m_out[i] = m_sh[i]; m_seen[i] = 1'b0;
        end
        m_stale = 1'b0;
      end
      m_pframe = 1'b0;
      if (m_pacc) begin
        m_sh[m_pidx] = m_pcode;
        m_seen[m_pidx] = 1'b1;
        m_idle = 0;
        all_seen = 1'b1;
        for (int i = 0; i < 4; i++) all_seen &= m_seen[i];
        m_pframe = all_seen;
      end else if (m_idle < T) begin
        m_idle++;
        if (m_idle == T) begin
          m_stale = 1'b1;
          for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        end
      end
      if (m_pill_an || (m_pacc && m_pbad)) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (m_run_len > 0 && {an, sg} == m_run_val) m_run_len++;
      else begin
        m_run_val = {an, sg};
        m_run_len = 1;
      end
      valid = ($countones(~an) == 1);
      for (int b = 0; b < 4; b++) if (!an[b]) m_pidx = b;
      decode(sg, m_pcode, m_pbad);
      m_pacc = valid && (m_run_len == S);
      m_pill_an = !valid && (an != 4'hF);
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] sg,
                      input logic clr, input logic rs);
    anodo_i   = an;
    catodo_i  = {1'($urandom), sg};
    clr_err_i = clr;
    rst_i     = rs;
    @(posedge clk_i);
    model_edge(an, sg, clr, rs);
    @(negedge clk_i);
    chk("cycle",
        {cuarto_disp_o, tercer_disp_o, segundo_disp_o, primer_disp_o,
         frame_valid_o, err_o, stale_o},
        {m_out[3], m_out[2], m_out[1], m_out[0], m_fv, m_err, m_stale});
    if (frame_valid_o) begin
      pulses++;
      stale_at_pulse = stale_o;
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] sg,
                       input int n);
    for (int k = 0; k < n; k++) step(an, sg, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    dwell(4'hF, 7'h7F, n);
  endtask

  function automatic logic [15:0] digits();
    return {cuarto_disp_o, tercer_disp_o, segundo_disp_o, primer_disp_o};
  endfunction

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    int r;
    int len;

    for (int k = 0; k < 3; k++) step(4'hF, 7'h7F, 1'b0, 1'b1);
    idle(10);
    chk("reset_digits", digits(), 16'hFFFF);
    chk("reset_flags", {frame_valid_o, err_o, stale_o}, 3'b000);

    pulses = 0;
    dwell(4'b1110, 7'h79, 4);
    dwell(4'b1101, 7'h24, 4);
    dwell(4'b1011, 7'h30, 4);
    dwell(4'b0111, 7'h19, 4);
    idle(3);
    chk("frame1_pulses", pulses, 1);
    chk("frame1_digits", digits(), 16'h4321);
    chk("frame1_err", err_o, 1'b0);

    pulses = 0;
    dwell(4'b1110, 7'h12, 4);
    dwell(4'b1101, 7'h10, 3);
    dwell(4'b1011, 7'h78, 4);
    dwell(4'b0111, 7'h00, 4);
    idle(3);
    chk("short_dwell_pulses", pulses, 0);
    dwell(4'b1101, 7'h02, 4);
    idle(3);
    chk("redo_pulses", pulses, 1);
    chk("redo_digits", digits(), 16'h8765);

    pulses = 0;
    dwell(4'b1110, 7'h40, 4);
    dwell(4'b1101, 7'h55, 4);
    dwell(4'b1011, 7'h79, 4);
    dwell(4'b0111, 7'h24, 4);
    idle(3);
    chk("illegal_pulses", pulses, 1);
    chk("illegal_digits", digits(), 16'h21F0);
    chk("illegal_err", err_o, 1'b1);
    idle(5);
    chk("err_sticky", err_o, 1'b1);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    chk("err_clear", err_o, 1'b0);

    idle(20);
    chk("stale_set", stale_o, 1'b1);
    pulses = 0;
    stale_at_pulse = 1'b1;
    dwell(4'b1110, 7'h08, 4);
    dwell(4'b1101, 7'h23, 4);
    dwell(4'b1011, 7'h46, 4);
    dwell(4'b0111, 7'h21, 4);
    idle(3);
    chk("stale_pulses", pulses, 1);
    chk("stale_at_pulse", stale_at_pulse, 1'b0);
    chk("stale_digits", digits(), 16'hDCBA);

    dwell(4'b1110, 7'h12, 4);
    dwell(4'b1101, 7'h02, 4);
    idle(1);
    step(4'hF, 7'h7F, 1'b0, 1'b1);
    chk("midreset_digits", digits(), 16'hFFFF);
    pulses = 0;
    dwell(4'b1110, 7'h10, 4);
    dwell(4'b1101, 7'h00, 4);
    dwell(4'b1011, 7'h78, 4);
    dwell(4'b0111, 7'h02, 4);
    idle(3);
    chk("after_reset_pulses", pulses, 1);
    chk("after_reset_digits", digits(), 16'h6789);
    chk("after_reset_err", err_o, 1'b0);
    step(4'b1100, 7'h40, 1'b0, 1'b0);
    idle(2);
    chk("bad_anode_err", err_o, 1'b1);

    for (int d = 0; d < 120; d++) begin
      r  = $urandom_range(0, 19);
      an = ~(4'(1) << $urandom_range(0, 3));
      sg = PAT[$urandom_range(0, 15)];
      if (r == 0) an = 4'hF;
      else if (r == 1) an = 4'($urandom);
      else if (r == 2) sg = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        step(an, sg, ($urandom_range(0, 15) == 0), 1'b0);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
